nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that performs a 4·NIBBLES-bit add or subtract by time-multiplexing a single 4-bit ripple-carry slice, one nibble per clock, least-significant nibble first. It sits between a requester issuing wide operands and the team's 4-bit full-adder datapath, and it owns operand capture, carry chaining between cycles, result assembly and a start/busy/done handshake. This trades NIBBLES cycles of latency for one adder slice instead of NIBBLES slices.

## Interface
- NIBBLES, default 4: operand width in nibbles (W = 4·NIBBLES). Legal range is 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled only while busy=0.
- Sub  in  1  0 = A+B; 1 = A−B, computed as A + ~B + 1.
- A  in  W  first operand, captured when start is accepted.
- B  in  W  second operand, captured when start is accepted.
- busy  out  1  high while nibbles are being processed.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- S  out  W  result register.
- Carry  out  1  carry out of the MSB. For subtract this is NOT borrow.
- Overflow  out  1  two's-complement signed overflow.

## Operation
- **Datapath:** one instance of a 4-bit slice built from four full_adder cells, with an external carry-in and a carry-out. No other adders are used for the sum.
- **States:** IDLE, RUN, DONE.
- **IDLE or DONE with start=1:**
  - Capture A into opA.
  - Capture B XOR {W{Sub}} into opB.
  - Load cin ← Sub and idx ← 0.
  - Go to RUN.
- **DONE with start=0:** go to IDLE.
- **RUN, each cycle:**
  - Slice inputs are opA[4·idx+:4], opB[4·idx+:4] and cin.
  - The slice sum is written into acc[4·idx+:4], and cin ← slice carry-out.
  - idx increments. When idx = NIBBLES−1, go to DONE on the same edge.
  - On that last edge also load S ← final acc and Carry ← final carry-out.
  - Load Overflow ← (opA[W−1] == opB[W−1]) && (sum MSB != opA[W−1]).
- **Holding results:** S, Carry and Overflow change only on the edge entering DONE. They hold until the next completion.
- **busy:** equals 1 exactly in RUN.
- **done:** equals 1 exactly in DONE.
- **start while busy=1:** ignored. No queuing and no effect on the operation in flight.
- **Operand changes:** changing A, B or Sub after acceptance has no effect.
- **idx width:** clog2(NIBBLES). idx never wraps past NIBBLES−1.

## Timing
- **Reset values** (async, immediate on rst_n=0):
  - state = IDLE, busy = 0, done = 0, S = 0, Carry = 0, Overflow = 0.
  - Internal opA, opB, acc, cin and idx are all 0.
- **Reset mid-RUN:** aborts the operation. No done pulse, and outputs return to reset values.
- **Acceptance:** start=1 at edge E0 with busy=0.
  - busy is high from E0 to E_NIBBLES, i.e. exactly NIBBLES cycles.
  - done is high from E_NIBBLES to E_NIBBLES+1, and S/Carry/Overflow are valid from E_NIBBLES.
- **Latency:** start edge to done is NIBBLES cycles. Issue interval is NIBBLES+1 cycles at best.
- **Back-to-back:** start held high during the DONE cycle is accepted at E_NIBBLES+1.
  - done drops and busy rises on that same edge.
  - S keeps the previous result until the new completion.
- **Combinational paths:** none from inputs to outputs. All outputs are registered.

## Test plan
All scenarios use NIBBLES=4.
1. After reset: start=1, A=0x1234, B=0x1111, Sub=0 at E0.
   - busy is high for 4 cycles, then done pulses once at E4.
   - S=0x2345, Carry=0, Overflow=0.
2. A=0xFFFF, B=0x0001, Sub=0 (carry across every nibble): S=0x0000, Carry=1, Overflow=0.
3. A=0x7FFF, B=0x0001, Sub=0: S=0x8000, Carry=0, Overflow=1.
4. Two subtracts, back-to-back:
   - A=0x0005, B=0x0007, Sub=1 gives S=0xFFFE, Carry=0, Overflow=0.
   - With start held during DONE, the second op A=0x8000, B=0x0001, Sub=1 is accepted at E5 and gives S=0x7FFF, Carry=1, Overflow=1 at E9.
5. Ignored start and mid-op changes:
   - Start an op (A=0x00F0, B=0x0010).
   - Pulse start with A=0xAAAA at E2 and change A, B at E1.
   - Only one done, at E4, with S=0x0100. No second operation starts.
6. Reset during RUN:
   - Assert rst_n=0 between E2 and E3.
   - busy, done, S, Carry and Overflow are 0 immediately, and no done follows.
   - A new start after release completes normally in 4 cycles.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Wide add/subtract done one nibble per clock through a single 4-bit
// ripple-carry slice, LS nibble first, with a start/busy/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 Sub,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] S,
  output logic                 Carry,
  output logic                 Overflow
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  logic [W-1:0]  opA, opB, acc, acc_next;
  logic          cin;
  logic [IW-1:0] idx;

  logic [3:0] slice_a, slice_b, slice_s;
  logic [4:0] chain;
  logic       accept, last;

  // A new request is only taken when no operation is in flight.
  assign accept = start && (state != RUN);
  assign last   = (idx == LAST_IDX);

  // Current nibble of each captured operand feeds the single slice.
  assign slice_a  = opA[{idx, 2'b00} +: 4];
  assign slice_b  = opB[{idx, 2'b00} +: 4];
  assign chain[0] = cin;

  // The one 4-bit ripple slice: four full adders chained on carry.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      full_adder u_fa (
        .a  (slice_a[gi]),
        .b  (slice_b[gi]),
        .ci (chain[gi]),
        .s  (slice_s[gi]),
        .co (chain[gi+1])
      );
    end
  endgenerate

  // Accumulator with the current slice sum merged into its nibble position.
  always_comb begin
    acc_next = acc;
    acc_next[{idx, 2'b00} +: 4] = slice_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand capture, nibble stepping, and result loading on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA      <= '0;
      opB      <= '0;
      acc      <= '0;
      cin      <= 1'b0;
      idx      <= '0;
      S        <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else if (accept) begin
      opA <= A;
      opB <= B ^ {W{Sub}};
      cin <= Sub;
      idx <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      cin <= chain[4];
      if (last) begin
        S        <= acc_next;
        Carry    <= chain[4];
        Overflow <= (opA[W-1] == opB[W-1]) && (acc_next[W-1] != opA[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl (NIBBLES=4): directed scenarios plus
// randomized operations checked against an arithmetic reference model.

module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        Sub;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] S;
  logic        Carry, Overflow;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_s;
  logic        exp_c, exp_o;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .Sub      (Sub),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .S        (S),
    .Carry    (Carry),
    .Overflow (Overflow)
  );

  // Reference: plain unsigned/signed arithmetic on the full-width operands.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic sub, output logic [15:0] s,
                                output logic c, output logic o);
    int sa, sb, r;
    logic [16:0] wide;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? (sa - sb) : (sa + sb);
    o  = (r > 32767) || (r < -32768);
    s  = sub ? (a - b) : (a + b);
    wide = {1'b0, a} + {1'b0, b};
    c  = sub ? (a >= b) : wide[16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_hs(input string tag, input logic eb, input logic ed);
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, eb});
    chk({tag, ".done"}, {15'd0, done}, {15'd0, ed});
  endtask

  task automatic chk_res(input string tag);
    chk({tag, ".S"}, S, exp_s);
    chk({tag, ".Carry"}, {15'd0, Carry}, {15'd0, exp_c});
    chk({tag, ".Ovf"}, {15'd0, Overflow}, {15'd0, exp_o});
  endtask

  // Issue one op now (DUT must be in IDLE or DONE) and follow it to DONE.
  // With noise set, junk starts/operands are driven while busy.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input bit noise);
    logic [15:0] ns;
    logic nc, no;
    A = a; B = b; Sub = sub; start = 1'b1;
    model(a, b, sub, ns, nc, no);
    tick();                                   // E0
    start = 1'b0;
    chk_hs({tag, ".e0"}, 1'b1, 1'b0);
    chk_res({tag, ".e0hold"});
    for (int k = 1; k <= 3; k++) begin
      if (noise) begin
        A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom);
        start = 1'($urandom);
      end
      tick();                                 // E1..E3
      chk_hs($sformatf("%s.e%0d", tag, k), 1'b1, 1'b0);
      chk({tag, ".hold"}, S, exp_s);
    end
    if (noise) start = 1'b1;
    tick();                                   // E4
    start = 1'b0;
    exp_s = ns; exp_c = nc; exp_o = no;
    chk_hs({tag, ".e4"}, 1'b0, 1'b1);
    chk_res({tag, ".e4"});
    $display("op %s A=%h B=%h Sub=%0d -> S=%h C=%0d V=%0d", tag, a, b, sub, S, Carry, Overflow);
  endtask

  // Let a DONE cycle lapse with start low and confirm return to idle.
  task automatic settle(input string tag);
    start = 1'b0;
    tick();
    chk_hs({tag, ".idle"}, 1'b0, 1'b0);
    chk_res({tag, ".idle"});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; Sub = 1'b0; A = '0; B = '0;
    exp_s = '0; exp_c = 1'b0; exp_o = 1'b0;
    #2;
    chk_hs("reset", 1'b0, 1'b0);
    chk_res("reset");
    #10 rst_n = 1'b1;
    tick();
    chk_hs("post_reset", 1'b0, 1'b0);

    // Directed scenarios
    run_op("t1", 16'h1234, 16'h1111, 1'b0, 1'b0); settle("t1");
    chk("t1.S_const", S, 16'h2345);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0); settle("t2");
    chk("t2.C_const", {15'd0, Carry}, 16'd1);
    run_op("t3", 16'h7FFF, 16'h0001, 1'b0, 1'b0); settle("t3");
    chk("t3.V_const", {15'd0, Overflow}, 16'd1);
    run_op("t4a", 16'h0005, 16'h0007, 1'b1, 1'b0);
    chk("t4a.S_const", S, 16'hFFFE);
    run_op("t4b", 16'h8000, 16'h0001, 1'b1, 1'b0);   // accepted during DONE
    chk("t4b.S_const", S, 16'h7FFF);
    settle("t4b");

    // Ignored start and operand changes while busy
    A = 16'h00F0; B = 16'h0010; Sub = 1'b0; start = 1'b1;
    model(16'h00F0, 16'h0010, 1'b0, exp_s, exp_c, exp_o);
    tick();                                          // E0
    start = 1'b0;
    chk_hs("t5.e0", 1'b1, 1'b0);
    A = 16'h1234; B = 16'h4321; Sub = 1'b1;
    tick();                                          // E1
    A = 16'hAAAA; start = 1'b1;
    tick();                                          // E2
    start = 1'b0;
    chk_hs("t5.e2", 1'b1, 1'b0);
    tick();                                          // E3
    chk_hs("t5.e3", 1'b1, 1'b0);
    tick();                                          // E4
    chk_hs("t5.e4", 1'b0, 1'b1);
    chk_res("t5.e4");
    chk("t5.S_const", S, 16'h0100);
    tick();                                          // E5
    chk_hs("t5.e5", 1'b0, 1'b0);
    tick();
    chk_hs("t5.e6", 1'b0, 1'b0);
    $display("op t5 ignored-start S=%h", S);

    // Reset in the middle of RUN
    A = 16'h4444; B = 16'h1111; Sub = 1'b0; start = 1'b1;
    tick();                                          // E0
    start = 1'b0;
    tick(); tick();                                  // E1, E2
    #2 rst_n = 1'b0;
    #1;
    exp_s = '0; exp_c = 1'b0; exp_o = 1'b0;
    chk_hs("t6.rst", 1'b0, 1'b0);
    chk_res("t6.rst");
    #10 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_hs("t6.nodone", 1'b0, 1'b0);
    end
    $display("op t6 reset-abort S=%h", S);
    run_op("t6new", 16'h0F0F, 16'h00F1, 1'b0, 1'b0); settle("t6new");

    // Randomized operations, some chained back-to-back, some with noise
    for (int n = 0; n < 24; n++) begin
      logic [15:0] ra, rb;
      logic rs;
      bit chain_next;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (n % 6 == 0) ra = 16'h8000 | ra;
      run_op($sformatf("r%0d", n), ra, rb, rs, bit'($urandom_range(0, 1)));
      chain_next = bit'($urandom_range(0, 1));
      if (!chain_next) settle($sformatf("r%0d", n));
    end
    settle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
